// File: rtl/flag_pkg.sv
// Shared types for the interrupt flag-context stack: the saved C/Z pair and the
// per-cycle stack operation decode used by the top level.
package flag_pkg;

    typedef struct packed {
        logic c;
        logic z;
    } flag_ctx_t;

    localparam int FLAG_CTX_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_PUSH,
        OP_PUSH_FULL,
        OP_POP,
        OP_POP_EMPTY,
        OP_SWAP,
        OP_PUSH_EMPTY_POP
    } stack_op_e;

    // A simultaneous push and pop on a non-empty stack swaps the top entry,
    // so full never blocks it; on an empty stack it degrades to a plain push.
    function automatic stack_op_e decode_op(input logic push,
                                            input logic pop,
                                            input logic full,
                                            input logic empty);
        stack_op_e op;
        op = OP_NONE;
        if (push && pop) begin
            op = empty ? OP_PUSH_EMPTY_POP : OP_SWAP;
        end else if (push) begin
            op = full ? OP_PUSH_FULL : OP_PUSH;
        end else if (pop) begin
            op = empty ? OP_POP_EMPTY : OP_POP;
        end
        return op;
    endfunction

endpackage

// File: rtl/flag_ctx_mem.sv
// DEPTH-entry storage for saved flag contexts: one synchronous write port and
// one combinational read port, with no reset on the array contents.
module flag_ctx_mem
    import flag_pkg::*;
#(
    parameter int DEPTH = FLAG_CTX_DEPTH_DEF,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  flag_ctx_t       wdata,
    input  logic [AW-1:0]   raddr,
    output flag_ctx_t       rdata
);

    flag_ctx_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/flag_ctx_stack.sv
// Saves the C/Z flag pair on interrupt entry and restores it on RETIE, driving
// a one-cycle restore_ld pulse into the flag registers' load path.
module flag_ctx_stack
    import flag_pkg::*;
#(
    parameter int DEPTH    = FLAG_CTX_DEPTH_DEF,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             c_in,
    input  logic             z_in,
    input  logic             push,
    input  logic             pop,
    input  logic             clr_err,
    output logic             c_out,
    output logic             z_out,
    output logic             restore_ld,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             ovf_err,
    output logic             unf_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    stack_op_e        op;
    logic [CNT_W-1:0] count_nxt;
    logic [CNT_W-1:0] top_idx;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [AW-1:0]    mem_raddr;
    flag_ctx_t        mem_wdata;
    flag_ctx_t        mem_rdata;
    logic             restore_valid;
    logic             ovf_evt;
    logic             unf_evt;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign top_idx = count - CNT_W'(1);

    flag_ctx_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    // Operation decode: picks the write slot, the next occupancy and the
    // error events; the read port always looks at the current top entry.
    always_comb begin
        op            = decode_op(push, pop, full, empty);
        count_nxt     = count;
        mem_we        = 1'b0;
        mem_waddr     = count[AW-1:0];
        mem_wdata     = '{c: c_in, z: z_in};
        mem_raddr     = top_idx[AW-1:0];
        restore_valid = 1'b0;
        ovf_evt       = 1'b0;
        unf_evt       = 1'b0;
        case (op)
            OP_PUSH: begin
                mem_we    = 1'b1;
                count_nxt = count + CNT_W'(1);
            end
            OP_PUSH_FULL: begin
                ovf_evt = 1'b1;
            end
            OP_POP: begin
                restore_valid = 1'b1;
                count_nxt     = top_idx;
            end
            OP_POP_EMPTY: begin
                unf_evt = 1'b1;
            end
            OP_SWAP: begin
                restore_valid = 1'b1;
                mem_we        = 1'b1;
                mem_waddr     = top_idx[AW-1:0];
            end
            OP_PUSH_EMPTY_POP: begin
                mem_we    = 1'b1;
                count_nxt = count + CNT_W'(1);
                unf_evt   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

    // Restored flags hold their last value between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_out      <= 1'b0;
            z_out      <= 1'b0;
            restore_ld <= 1'b0;
        end else begin
            restore_ld <= restore_valid;
            if (restore_valid) begin
                c_out <= mem_rdata.c;
                z_out <= mem_rdata.z;
            end
        end
    end

    // A new error event wins over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            ovf_err <= ovf_evt | (ovf_err & ~clr_err);
            unf_err <= unf_evt | (unf_err & ~clr_err);
        end
    end

endmodule

// File: tb/tb_flag_ctx_stack.sv
// Scoreboard bench for flag_ctx_stack: a queue-based stack model predicts the
// state after every clock edge and a negedge monitor compares the DUT to it.
module tb_flag_ctx_stack;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    typedef struct {
        int cyc;
        int cnt;
        bit ld;
        bit c;
        bit z;
        bit ovf;
        bit unf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             c_in = 1'b0;
    logic             z_in = 1'b0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic             clr_err = 1'b0;
    logic             c_out;
    logic             z_out;
    logic             restore_ld;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             ovf_err;
    logic             unf_err;

    int   assertions = 0;
    int   failures = 0;
    int   cycle = 0;
    bit   started = 1'b0;
    exp_t exp_q[$];

    bit [1:0] model_stack[$];
    bit       model_c = 1'b0;
    bit       model_z = 1'b0;
    bit       model_ovf = 1'b0;
    bit       model_unf = 1'b0;

    flag_ctx_stack #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .c_in       (c_in),
        .z_in       (z_in),
        .push       (push),
        .pop        (pop),
        .clr_err    (clr_err),
        .c_out      (c_out),
        .z_out      (z_out),
        .restore_ld (restore_ld),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .ovf_err    (ovf_err),
        .unf_err    (unf_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertions++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cycle, actual, expected);
        end
    endtask

    function automatic exp_t model_snapshot(input int due);
        exp_t e;
        e.cyc = due;
        e.cnt = model_stack.size();
        e.ld  = 1'b0;
        e.c   = model_c;
        e.z   = model_z;
        e.ovf = model_ovf;
        e.unf = model_unf;
        return e;
    endfunction

    // Drive one cycle of stimulus and predict the state after the next edge.
    task automatic applyStimulus(input bit p_push, input bit p_pop, input bit p_c,
                                 input bit p_z, input bit p_clr);
        exp_t e;
        bit   ld = 1'b0;
        bit   ovf_evt = 1'b0;
        bit   unf_evt = 1'b0;
        bit [1:0] top;
        rst     = 1'b0;
        push    = p_push;
        pop     = p_pop;
        c_in    = p_c;
        z_in    = p_z;
        clr_err = p_clr;
        if (p_pop && model_stack.size() > 0) begin
            top = model_stack.pop_back();
            {model_c, model_z} = top;
            ld = 1'b1;
            if (p_push) model_stack.push_back({p_c, p_z});
        end else if (p_pop) begin
            unf_evt = 1'b1;
            if (p_push) model_stack.push_back({p_c, p_z});
        end else if (p_push) begin
            if (model_stack.size() < DEPTH) model_stack.push_back({p_c, p_z});
            else ovf_evt = 1'b1;
        end
        model_ovf = ovf_evt | (model_ovf & ~p_clr);
        model_unf = unf_evt | (model_unf & ~p_clr);
        e = model_snapshot(cycle + 1);
        e.ld = ld;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Reset between edges: the DUT must clear without a clock.
    task automatic applyReset();
        exp_t e;
        push = 1'b0;
        pop = 1'b0;
        clr_err = 1'b0;
        rst = 1'b1;
        model_stack.delete();
        model_c = 1'b0;
        model_z = 1'b0;
        model_ovf = 1'b0;
        model_unf = 1'b0;
        #1;
        checkOutput("async_count", int'(count), 0);
        checkOutput("async_restore_ld", int'(restore_ld), 0);
        e = model_snapshot(cycle);
        if (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc == cycle)
            exp_q[exp_q.size()-1] = e;
        e.cyc = cycle + 1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cycle) begin
                e = exp_q.pop_front();
                checkOutput("missed_expectation", cycle, e.cyc);
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cycle) begin
                e = exp_q.pop_front();
                checkOutput("count", int'(count), e.cnt);
                checkOutput("full", int'(full), int'(e.cnt == DEPTH));
                checkOutput("empty", int'(empty), int'(e.cnt == 0));
                checkOutput("restore_ld", int'(restore_ld), int'(e.ld));
                checkOutput("c_out", int'(c_out), int'(e.c));
                checkOutput("z_out", int'(z_out), int'(e.z));
                checkOutput("ovf_err", int'(ovf_err), int'(e.ovf));
                checkOutput("unf_err", int'(unf_err), int'(e.unf));
            end
        end
    end

    initial begin
        bit rp, rq, rc, rz, rclr;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset_count", int'(count), 0);
        checkOutput("reset_empty", int'(empty), 1);
        checkOutput("reset_full", int'(full), 0);
        checkOutput("reset_restore_ld", int'(restore_ld), 0);
        checkOutput("reset_cz", int'({c_out, z_out}), 0);
        checkOutput("reset_errs", int'({ovf_err, unf_err}), 0);
        started = 1'b1;

        applyStimulus(1, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        applyStimulus(1, 0, 1, 1, 0);
        applyStimulus(1, 0, 0, 1, 0);
        applyStimulus(1, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        applyStimulus(1, 0, 1, 1, 0);
        applyStimulus(1, 0, 0, 1, 0);
        applyStimulus(1, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);

        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 1, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);

        applyStimulus(1, 0, 1, 1, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        for (int i = 0; i < 3; i++) applyStimulus(1, 0, i[0], 1, 0);
        applyReset();

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                applyReset();
            end else begin
                rp   = ($urandom_range(0, 99) < 45);
                rq   = ($urandom_range(0, 99) < 40);
                rc   = 1'($urandom);
                rz   = 1'($urandom);
                rclr = ($urandom_range(0, 99) < 8);
                applyStimulus(rp, rq, rc, rz, rclr);
            end
        end
        push = 1'b0;
        pop = 1'b0;
        clr_err = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
